// File: rtl/calc2_port_if.sv
// Request/response bundle for one calc2 port: master drives requests, the
// engine (slave) answers with tagged responses and reports queue status.
interface calc2_port_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    req_cmd_in;
  logic [31:0]   req_data_in;
  logic [1:0]    req_tag_in;
  logic [1:0]    out_resp;
  logic [31:0]   out_data;
  logic [1:0]    out_tag;
  logic [CW-1:0] fifo_count;
  logic          drop_pulse;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  out_resp, out_data, out_tag, fifo_count, drop_pulse
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output out_resp, out_data, out_tag, fifo_count, drop_pulse
  );
endinterface

// File: rtl/calc2_port_engine.sv
// Responder for one calc2 port: captures two-cycle requests, queues them in
// order, runs add/sub/shift and returns one tagged response per accepted request.
//   state  | meaning
//   S_IDLE | waiting for a nonzero cmd; cmd, op1 and tag latched on exit
//   S_OP2  | operand2 sampled on this edge and pushed into the FIFO
module calc2_port_engine #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input logic         c_clk,
  input logic         reset,
  calc2_port_if.slave port
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(ALU_LAT + 1);

  typedef enum logic {S_IDLE, S_OP2} cap_state_t;

  cap_state_t    state, state_nxt;
  logic          cap_en, wr_try, wr_ok, pop;
  logic [3:0]    cap_cmd;
  logic [31:0]   cap_op1;
  logic [1:0]    cap_tag;

  logic [3:0]    fifo_cmd [DEPTH];
  logic [31:0]   fifo_op1 [DEPTH];
  logic [31:0]   fifo_op2 [DEPTH];
  logic [1:0]    fifo_tag [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          drop_q;

  logic          alu_busy;
  logic [TW-1:0] alu_cnt;
  logic [1:0]    res_resp, head_resp, resp_q;
  logic [31:0]   res_data, head_data, data_q;
  logic [1:0]    res_tag, tag_q;
  logic [32:0]   sum;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    wr_try    = 1'b0;
    case (state)
      S_IDLE: if (port.req_cmd_in != 4'h0) begin
        cap_en    = 1'b1;
        state_nxt = S_OP2;
      end
      S_OP2: begin
        wr_try    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      cap_cmd <= '0;
      cap_op1 <= '0;
      cap_tag <= '0;
    end else if (cap_en) begin
      cap_cmd <= port.req_cmd_in;
      cap_op1 <= port.req_data_in;
      cap_tag <= port.req_tag_in;
    end
  end

  // A full FIFO still accepts when the head leaves on the same edge.
  assign pop   = !alu_busy && (count != '0);
  assign wr_ok = wr_try && ((count < CW'(DEPTH)) || pop);

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_cmd[i] <= '0;
        fifo_op1[i] <= '0;
        fifo_op2[i] <= '0;
        fifo_tag[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        fifo_cmd[wr_ptr] <= cap_cmd;
        fifo_op1[wr_ptr] <= cap_op1;
        fifo_op2[wr_ptr] <= port.req_data_in;
        fifo_tag[wr_ptr] <= cap_tag;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (wr_ok && !pop)      count <= count + CW'(1);
      else if (pop && !wr_ok) count <= count - CW'(1);
      drop_q <= wr_try && !wr_ok;
    end
  end

  always_comb begin
    head_resp = 2'b10;
    head_data = '0;
    sum       = {1'b0, fifo_op1[rd_ptr]} + {1'b0, fifo_op2[rd_ptr]};
    case (fifo_cmd[rd_ptr])
      4'h1: if (!sum[32]) begin
        head_resp = 2'b01;
        head_data = sum[31:0];
      end
      4'h2: if (fifo_op2[rd_ptr] <= fifo_op1[rd_ptr]) begin
        head_resp = 2'b01;
        head_data = fifo_op1[rd_ptr] - fifo_op2[rd_ptr];
      end
      4'h5: begin
        head_resp = 2'b01;
        head_data = fifo_op1[rd_ptr] << fifo_op2[rd_ptr][4:0];
      end
      4'h6: begin
        head_resp = 2'b01;
        head_data = fifo_op1[rd_ptr] >> fifo_op2[rd_ptr][4:0];
      end
      default: ;
    endcase
  end

  // Result is computed at load; the down-counter only paces its release.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      alu_busy <= 1'b0;
      alu_cnt  <= '0;
      res_resp <= '0;
      res_data <= '0;
      res_tag  <= '0;
      resp_q   <= '0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      resp_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
      if (pop) begin
        alu_busy <= 1'b1;
        alu_cnt  <= TW'(ALU_LAT);
        res_resp <= head_resp;
        res_data <= head_data;
        res_tag  <= fifo_tag[rd_ptr];
      end else if (alu_busy) begin
        alu_cnt <= alu_cnt - TW'(1);
        if (alu_cnt == TW'(1)) begin
          alu_busy <= 1'b0;
          resp_q   <= res_resp;
          data_q   <= res_data;
          tag_q    <= res_tag;
        end
      end
    end
  end

  assign port.out_resp   = resp_q;
  assign port.out_data   = data_q;
  assign port.out_tag    = tag_q;
  assign port.fifo_count = count;
  assign port.drop_pulse = drop_q;
endmodule

// File: tb/tb_calc2_port_engine.sv
// Bench for calc2_port_engine: directed cases plus random requests checked
// cycle by cycle against a request-level timing and arithmetic model.
module tb_calc2_port_engine;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;

  logic c_clk = 1'b0;
  logic reset = 1'b1;

  calc2_port_if #(.DEPTH(DEPTH)) pif();

  calc2_port_engine #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .port  (pif.slave)
  );

  always #5 c_clk = ~c_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int tick   = 0;

  // Model: per accepted request its write edge, load edge, response edge and result.
  int          e_q[$];
  int          l_q[$];
  int          r_q[$];
  logic [1:0]  xr_q[$];
  logic [31:0] xd_q[$];
  logic [1:0]  xt_q[$];
  int          drop_q[$];
  int          last_r;

  logic [3:0]  p_cmd;
  logic [31:0] p_op1;
  logic [1:0]  p_tag;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  t;
    logic [1:0]  r;
    logic [31:0] d;
  } dcase_t;

  dcase_t dir [7];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s tick=%0d got=%0h want=%0h", name, tick, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_q.delete(); l_q.delete(); r_q.delete();
    xr_q.delete(); xd_q.delete(); xt_q.delete(); drop_q.delete();
    last_r = -1000;
  endtask

  task automatic calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      output logic [1:0] r, output logic [31:0] d);
    logic [63:0] s;
    r = 2'b10;
    d = 32'h0;
    s = {32'h0, a} + {32'h0, b};
    case (c)
      4'h1: if (s < 64'h1_0000_0000) begin r = 2'b01; d = s[31:0]; end
      4'h2: if (b <= a) begin r = 2'b01; d = a - b; end
      4'h5: begin r = 2'b01; d = a << (b % 32); end
      4'h6: begin r = 2'b01; d = a >> (b % 32); end
      default: ;
    endcase
  endtask

  task automatic model_write(input int e, input logic [3:0] c, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] t);
    int cnt = 0;
    bit popping = 0;
    int l;
    logic [1:0] r;
    logic [31:0] d;
    foreach (e_q[j]) begin
      if (e_q[j] < e && e <= l_q[j]) cnt++;
      if (l_q[j] == e) popping = 1;
    end
    if (cnt < DEPTH || popping) begin
      l = (e + 1 > last_r + 1) ? e + 1 : last_r + 1;
      calc(c, a, b, r, d);
      e_q.push_back(e); l_q.push_back(l); r_q.push_back(l + ALU_LAT);
      xr_q.push_back(r); xd_q.push_back(d); xt_q.push_back(t);
      last_r = l + ALU_LAT;
    end else begin
      drop_q.push_back(e);
    end
  endtask

  task automatic check_cycle();
    int xc = 0;
    logic xdrop = 1'b0;
    logic [1:0] xr = 2'b00;
    logic [31:0] xd = 32'h0;
    logic [1:0] xt = 2'b00;
    foreach (e_q[j]) begin
      if (e_q[j] <= tick && tick < l_q[j]) xc++;
      if (r_q[j] == tick) begin xr = xr_q[j]; xd = xd_q[j]; xt = xt_q[j]; end
    end
    foreach (drop_q[j]) if (drop_q[j] == tick) xdrop = 1'b1;
    chk("out_resp", 32'(pif.out_resp), 32'(xr));
    chk("out_data", pif.out_data, xd);
    chk("out_tag", 32'(pif.out_tag), 32'(xt));
    chk("fifo_count", 32'(pif.fifo_count), xc);
    chk("drop_pulse", 32'(pif.drop_pulse), 32'(xdrop));
  endtask

  task automatic step(input bit op2_edge);
    @(posedge c_clk);
    tick++;
    if (op2_edge && !reset) model_write(tick, p_cmd, p_op1, pif.req_data_in, p_tag);
    #1;
    check_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0);
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] t, input logic [3:0] c2);
    p_cmd = c; p_op1 = a; p_tag = t;
    pif.req_cmd_in = c; pif.req_data_in = a; pif.req_tag_in = t;
    step(0);
    pif.req_cmd_in = c2; pif.req_data_in = b; pif.req_tag_in = 2'($urandom);
    step(1);
    pif.req_cmd_in = 4'h0; pif.req_data_in = $urandom; pif.req_tag_in = 2'($urandom);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    int          sel;

    dir[0] = '{4'h1, 32'h30,       32'h20,       2'd1, 2'b01, 32'h50};
    dir[1] = '{4'h1, 32'hFFFFFFFF, 32'h1,        2'd2, 2'b10, 32'h0};
    dir[2] = '{4'h2, 32'h5,        32'h6,        2'd3, 2'b10, 32'h0};
    dir[3] = '{4'h2, 32'h6,        32'h6,        2'd0, 2'b01, 32'h0};
    dir[4] = '{4'h3, 32'h7,        32'h8,        2'd1, 2'b10, 32'h0};
    dir[5] = '{4'h5, 32'h1,        32'h1F,       2'd2, 2'b01, 32'h80000000};
    dir[6] = '{4'h6, 32'h80000000, 32'h24,       2'd3, 2'b01, 32'h08000000};

    model_reset();
    pif.req_cmd_in = 4'h0; pif.req_data_in = 32'h0; pif.req_tag_in = 2'b00;
    #2;
    chk("rst_resp", 32'(pif.out_resp), 32'h0);
    chk("rst_count", 32'(pif.fifo_count), 32'h0);
    idle(2);
    reset = 1'b0;
    idle(2);

    foreach (dir[i]) begin
      issue(dir[i].c, dir[i].a, dir[i].b, dir[i].t, 4'h0);
      idle(2);
      chk("dir_early", 32'(pif.out_resp), 32'h0);
      idle(1);
      chk("dir_resp", 32'(pif.out_resp), 32'(dir[i].r));
      chk("dir_data", pif.out_data, dir[i].d);
      chk("dir_tag", 32'(pif.out_tag), 32'(dir[i].t));
      idle(1);
      chk("dir_clear", 32'(pif.out_resp), 32'h0);
      idle(2);
    end

    for (int i = 0; i < 7; i++) issue(4'h1, 32'(i), 32'h100, 2'(i), 4'h0);
    idle(30);

    // Long back-to-back burst with junk cmds in the operand2 cycle: fills the
    // FIFO, drops at full, and hits accept-at-full on a pop edge.
    for (int i = 0; i < 18; i++) issue(4'h1, 32'(i * 3), 32'h7, 2'(i), 4'($urandom_range(1, 15)));
    idle(60);

    for (int i = 0; i < 5; i++) issue(4'h2, 32'h1000, 32'(i), 2'(i), 4'h0);
    pif.req_cmd_in = 4'h1; pif.req_data_in = 32'h55; pif.req_tag_in = 2'd2;
    p_cmd = 4'h1; p_op1 = 32'h55; p_tag = 2'd2;
    step(0);
    chk("pre_rst_count", 32'(pif.fifo_count), 32'd2);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_resp", 32'(pif.out_resp), 32'h0);
    chk("arst_data", pif.out_data, 32'h0);
    chk("arst_count", 32'(pif.fifo_count), 32'h0);
    chk("arst_drop", 32'(pif.drop_pulse), 32'h0);
    pif.req_data_in = 32'h66; pif.req_cmd_in = 4'h0;
    idle(2);
    reset = 1'b0;
    idle(2);
    issue(4'h1, 32'h30, 32'h20, 2'd1, 4'h0);
    idle(3);
    chk("post_rst_data", pif.out_data, 32'h50);
    chk("post_rst_resp", 32'(pif.out_resp), 32'h1);
    idle(12);

    repeat (400) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      case (sel)
        0, 1, 2: c = 4'h1;
        3, 4:    c = 4'h2;
        5:       c = 4'h5;
        6:       c = 4'h6;
        7:       c = 4'($urandom_range(7, 15));
        8:       c = 4'($urandom_range(3, 4));
        default: begin c = 4'h1; a = 32'($urandom_range(0, 255)); end
      endcase
      if (sel == 4) b = a + 32'($urandom_range(0, 2)) - 32'd1;
      issue(c, a, b, 2'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
      idle($urandom_range(0, 3));
    end
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
